// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter_n
// Description : N-digit packed-BCD up/down counter with synchronous clear,
//               clamped parallel load, and wrap or saturate end-of-range mode.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   clr     in   synchronous clear to zero (below reset in priority)
//   load    in   parallel load from din (below clr in priority)
//   din     in   packed BCD load value, digit k = din[4k+3:4k]
//   en      in   count enable, one step per cycle (lowest priority)
//   up      in   direction, 1 = up, 0 = down
//   q       out  registered packed BCD count
//   tc      out  registered one-cycle pulse after a wrap
//   at_lim  out  registered level, saturate mode: last enabled step blocked
//   ld_err  out  registered one-cycle pulse after a load with a digit > 9
//
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_n #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  at_lim,
  output logic                  ld_err
);

  localparam int W = 4 * DIGITS;

  // carry[k] / borrow[k]: digit k steps this cycle when counting up / down.
  // carry[DIGITS] is set only when every digit is 9 (MAX); borrow[DIGITS]
  // only when every digit is 0 (MIN).
  logic [DIGITS:0]   carry;
  logic [DIGITS:0]   borrow;
  logic [W-1:0]      inc_val;
  logic [W-1:0]      dec_val;
  logic [W-1:0]      din_clamped;
  logic [DIGITS-1:0] din_bad;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [3:0] d;
      logic [3:0] dl;

      assign d  = q[4*k +: 4];
      assign dl = din[4*k +: 4];

      assign carry[k+1]  = carry[k]  & (d == 4'd9);
      assign borrow[k+1] = borrow[k] & (d == 4'd0);

      assign inc_val[4*k +: 4] = carry[k]
                               ? ((d == 4'd9) ? 4'd0 : d + 4'd1)
                               : d;
      assign dec_val[4*k +: 4] = borrow[k]
                               ? ((d == 4'd0) ? 4'd9 : d - 4'd1)
                               : d;

      // Codes A..F are clamped to 9 so q never holds a non-decimal nibble.
      assign din_bad[k]            = (dl > 4'd9);
      assign din_clamped[4*k +: 4] = din_bad[k] ? 4'd9 : dl;
    end
  endgenerate

  logic at_max;
  logic at_min;
  logic at_edge;

  assign at_max  = carry[DIGITS];
  assign at_min  = borrow[DIGITS];
  assign at_edge = up ? at_max : at_min;

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      tc     <= 1'b0;
      at_lim <= 1'b0;
      ld_err <= 1'b0;
    end else if (clr) begin
      q      <= '0;
      tc     <= 1'b0;
      at_lim <= 1'b0;
      ld_err <= 1'b0;
    end else if (load) begin
      q      <= din_clamped;
      tc     <= 1'b0;
      at_lim <= 1'b0;
      ld_err <= |din_bad;
    end else if (en) begin
      ld_err <= 1'b0;
      if (SATURATE && at_edge) begin
        // Blocked step: hold the count and flag the limit.
        at_lim <= 1'b1;
        tc     <= 1'b0;
      end else begin
        // In wrap mode the ripple already yields 0 above MAX and all-9s
        // below MIN, so the limit only needs to raise tc.
        q      <= up ? inc_val : dec_val;
        tc     <= at_edge;
        at_lim <= 1'b0;
      end
    end else begin
      tc     <= 1'b0;
      ld_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_counter_n
// Description : Directed self-checking bench for bcd_counter_n. Four
//               instances (3-digit wrap, 3-digit saturate, 1-digit, 8-digit)
//               share control inputs; each phase checks the relevant one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset, clr, load, en, up;
  logic [11:0] din3;
  logic [3:0]  din1;
  logic [31:0] din8;

  logic [11:0] q3, qs;
  logic [3:0]  q1;
  logic [31:0] q8;
  logic tc3, al3, le3, tcs, als, les, tc1, al1, le1, tc8, al8, le8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b0)) u_w3 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din3), .en(en), .up(up),
    .q(q3), .tc(tc3), .at_lim(al3), .ld_err(le3));

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b1)) u_s3 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din3), .en(en), .up(up),
    .q(qs), .tc(tcs), .at_lim(als), .ld_err(les));

  bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_w1 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din1), .en(en), .up(up),
    .q(q1), .tc(tc1), .at_lim(al1), .ld_err(le1));

  bcd_counter_n #(.DIGITS(8), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din8), .en(en), .up(up),
    .q(q8), .tc(tc8), .at_lim(al8), .ld_err(le8));

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd3(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  initial begin
    int tc_count;
    int exp_v;
    bit seq_ok;

    reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
    din3 = '0; din1 = '0; din8 = '0;

    // Reset state on every instance
    tick();
    chk("rst_q3",  32'(q3),  32'h0);
    chk("rst_tc3", 32'(tc3), 32'h0);
    chk("rst_al3", 32'(al3), 32'h0);
    chk("rst_le3", 32'(le3), 32'h0);
    chk("rst_qs",  32'(qs),  32'h0);
    chk("rst_q1",  32'(q1),  32'h0);
    chk("rst_q8",  32'(q8),  32'h0);

    // 1000 up-steps: 000 -> 999 -> 000, tc exactly once when q returns to 000
    reset = 1'b0; en = 1'b1; up = 1'b1;
    tc_count = 0;
    seq_ok   = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      exp_v = i % 1000;
      if (q3 !== to_bcd3(exp_v) || tc3 !== (exp_v == 0)) begin
        if (seq_ok) chk("upcount_step", {q3, 3'b0, tc3}, {to_bcd3(exp_v), 3'b0, 1'(exp_v == 0)});
        seq_ok = 1'b0;
      end
      if (tc3 === 1'b1) tc_count++;
    end
    chk("upcount_final_q", 32'(q3), 32'h000);
    chk("upcount_tc_once", 32'(tc_count), 32'd1);
    chk("upcount_al", 32'(al3), 32'h0);

    // Down-count borrow from 100
    load = 1'b1; din3 = 12'h100; en = 1'b1; up = 1'b0;
    tick();
    chk("dn_load", 32'(q3), 32'h100);
    load = 1'b0;
    tick();
    chk("dn_099", 32'(q3), 32'h099);
    tick();
    chk("dn_098", 32'(q3), 32'h098);
    for (int i = 0; i < 98; i++) tick();
    chk("dn_000", 32'(q3), 32'h000);
    chk("dn_000_tc", 32'(tc3), 32'h0);
    tick();
    chk("dn_wrap_q", 32'(q3), 32'h999);
    chk("dn_wrap_tc", 32'(tc3), 32'h1);
    tick();
    chk("dn_998", 32'(q3), 32'h998);
    chk("dn_tc_drop", 32'(tc3), 32'h0);

    // Saturate mode
    en = 1'b0; load = 1'b1; din3 = 12'h998;
    tick();
    chk("sat_load", 32'(qs), 32'h998);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("sat_q1", 32'(qs), 32'h999);
    chk("sat_al1", 32'(als), 32'h0);
    tick();
    chk("sat_q2", 32'(qs), 32'h999);
    chk("sat_al2", 32'(als), 32'h1);
    chk("sat_tc2", 32'(tcs), 32'h0);
    tick();
    chk("sat_q3", 32'(qs), 32'h999);
    chk("sat_al3", 32'(als), 32'h1);
    chk("sat_tc3", 32'(tcs), 32'h0);
    en = 1'b0;
    tick();
    chk("sat_hold_al", 32'(als), 32'h1);
    en = 1'b1; up = 1'b0;
    tick();
    chk("sat_down_q", 32'(qs), 32'h998);
    chk("sat_down_al", 32'(als), 32'h0);

    // Invalid load clamping
    en = 1'b0; load = 1'b1; din3 = 12'h3C5;
    tick();
    chk("inv_q", 32'(q3), 32'h395);
    chk("inv_err", 32'(le3), 32'h1);
    load = 1'b0;
    tick();
    chk("inv_err_drop", 32'(le3), 32'h0);
    chk("inv_q_hold", 32'(q3), 32'h395);
    load = 1'b1; din3 = 12'h123;
    tick();
    chk("ok_q", 32'(q3), 32'h123);
    chk("ok_err", 32'(le3), 32'h0);

    // Priority
    clr = 1'b1; load = 1'b1; din3 = 12'h555; en = 1'b1; up = 1'b1;
    tick();
    chk("pri_clr", 32'(q3), 32'h000);
    clr = 1'b0;
    tick();
    chk("pri_load", 32'(q3), 32'h555);
    load = 1'b0;
    tick();
    chk("pri_step_after_load", 32'(q3), 32'h556);
    reset = 1'b1;
    tick();
    chk("pri_rst_q", 32'(q3), 32'h000);
    chk("pri_rst_flags", {29'b0, tc3, al3, le3}, 32'h0);
    reset = 1'b0;
    tick();
    chk("pri_resume", 32'(q3), 32'h001);

    // Width sweep
    en = 1'b0; load = 1'b1; din1 = 4'h9; din8 = 32'h09999999;
    tick();
    chk("w1_load", 32'(q1), 32'h9);
    chk("w8_load", q8, 32'h09999999);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("w1_wrap_q", 32'(q1), 32'h0);
    chk("w1_wrap_tc", 32'(tc1), 32'h1);
    chk("w8_carry", q8, 32'h10000000);
    chk("w8_tc", 32'(tc8), 32'h0);
    tick();
    chk("w1_next", 32'(q1), 32'h1);
    chk("w1_tc_drop", 32'(tc1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
